// File: rtl/pisa_mem_pkg.sv
// Shared types for the pixel-memory port-B arbiter: widths, FSM states and
// the read-return tag carried through the RAM read latency.
package pisa_mem_pkg;
   localparam int ADDR_W = 19;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

   typedef logic req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;
endpackage

// File: rtl/pixel_ram_arbiter_rd_return_pipe.sv
// Tracks which requester issued each read so ram_q can be steered back to it
// exactly READ_LATENCY cycles after the address cycle.
module rd_return_pipe
   import pisa_mem_pkg::*;
#(
   parameter int READ_LATENCY = 2
) (
   input  logic    clock,
   input  logic    rst_n,
   input  rd_tag_t tag_in,
   output logic    rvalid0,
   output logic    rvalid1
);

   rd_tag_t tag_pipe [READ_LATENCY];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= '0;
      end else begin
         tag_pipe[0] <= tag_in;
         for (int i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   assign rvalid0 = tag_pipe[READ_LATENCY-1].valid & (tag_pipe[READ_LATENCY-1].id == 1'b0);
   assign rvalid1 = tag_pipe[READ_LATENCY-1].valid & (tag_pipe[READ_LATENCY-1].id == 1'b1);

endmodule

// File: rtl/pixel_ram_arbiter.sv
// Round-robin arbiter sharing RAM_pixels port B between the image loader (r0)
// and the processor load/store unit (r1), with bounded bursts per owner.
module pixel_ram_arbiter #(
   parameter int ADDR_W       = pisa_mem_pkg::ADDR_W,
   parameter int DATA_W       = pisa_mem_pkg::DATA_W,
   parameter int READ_LATENCY = 2,
   parameter int MAX_BURST    = 16
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic                r0_req,
   input  logic                r0_we,
   input  logic [ADDR_W-1:0]   r0_addr,
   input  logic [DATA_W-1:0]   r0_wdata,
   input  logic [DATA_W/8-1:0] r0_be,
   output logic                r0_gnt,
   output logic                r0_rvalid,
   output logic [DATA_W-1:0]   r0_rdata,
   input  logic                r1_req,
   input  logic                r1_we,
   input  logic [ADDR_W-1:0]   r1_addr,
   input  logic [DATA_W-1:0]   r1_wdata,
   input  logic [DATA_W/8-1:0] r1_be,
   output logic                r1_gnt,
   output logic                r1_rvalid,
   output logic [DATA_W-1:0]   r1_rdata,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W-1:0]   ram_data,
   output logic [DATA_W/8-1:0] ram_byteena,
   output logic                ram_wren,
   input  logic [DATA_W-1:0]   ram_q
);
   import pisa_mem_pkg::*;

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   arb_state_t       state, state_nxt, other_state;
   logic             ptr, ptr_nxt;
   logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
   req_id_t          owner;
   logic             own_req, own_we, other_req;
   rd_tag_t          rd_tag;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= 1'b0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      beat_cnt_nxt = beat_cnt;
      owner        = 1'b0;
      own_req      = 1'b0;
      own_we       = 1'b0;
      other_req    = 1'b0;
      other_state  = IDLE;
      r0_gnt       = 1'b0;
      r1_gnt       = 1'b0;
      ram_address  = '0;
      ram_data     = '0;
      ram_byteena  = '0;
      ram_wren     = 1'b0;

      unique case (state)
         IDLE: begin
            if (r0_req && r1_req) state_nxt = ptr ? OWN1 : OWN0;
            else if (r0_req)      state_nxt = OWN0;
            else if (r1_req)      state_nxt = OWN1;
         end
         OWN0: begin
            owner       = 1'b0;
            own_req     = r0_req;
            own_we      = r0_we;
            other_req   = r1_req;
            other_state = OWN1;
            r0_gnt      = r0_req;
            ram_address = r0_addr;
            ram_data    = r0_wdata;
            ram_byteena = r0_be;
            ram_wren    = r0_req & r0_we;
         end
         OWN1: begin
            owner       = 1'b1;
            own_req     = r1_req;
            own_we      = r1_we;
            other_req   = r0_req;
            other_state = OWN0;
            r1_gnt      = r1_req;
            ram_address = r1_addr;
            ram_data    = r1_wdata;
            ram_byteena = r1_be;
            ram_wren    = r1_req & r1_we;
         end
         default: state_nxt = IDLE;
      endcase

      // Ownership ends on a dropped request or a full burst with the other side waiting
      if (state != IDLE) begin
         if (!own_req) begin
            state_nxt    = other_req ? other_state : IDLE;
            beat_cnt_nxt = '0;
            ptr_nxt      = ~owner;
         end else if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            if (other_req) begin
               state_nxt = other_state;
               ptr_nxt   = ~owner;
            end
         end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
         end
      end
   end

   assign rd_tag.valid = (r0_gnt | r1_gnt) & ~own_we;
   assign rd_tag.id    = owner;

   rd_return_pipe #(
      .READ_LATENCY(READ_LATENCY)
   ) u_rd_return_pipe (
      .clock  (clock),
      .rst_n  (rst_n),
      .tag_in (rd_tag),
      .rvalid0(r0_rvalid),
      .rvalid1(r1_rvalid)
   );

   assign r0_rdata = ram_q;
   assign r1_rdata = ram_q;

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Directed bench for pixel_ram_arbiter with a small port-B RAM stub of latency 2.
module tb_pixel_ram_arbiter;
   localparam int AW = 19;
   localparam int DW = 32;
   localparam int BW = 4;

   logic          clock;
   logic          rst_n;
   logic          r0_req, r0_we, r0_gnt, r0_rvalid;
   logic [AW-1:0] r0_addr;
   logic [DW-1:0] r0_wdata, r0_rdata;
   logic [BW-1:0] r0_be;
   logic          r1_req, r1_we, r1_gnt, r1_rvalid;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r1_wdata, r1_rdata;
   logic [BW-1:0] r1_be;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data, ram_q;
   logic [BW-1:0] ram_byteena;
   logic          ram_wren;

   int checks   = 0;
   int failures = 0;

   pixel_ram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2), .MAX_BURST(16)
   ) dut (
      .clock(clock), .rst_n(rst_n),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_be(r0_be),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_be(r1_be),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .ram_address(ram_address), .ram_data(ram_data), .ram_byteena(ram_byteena),
      .ram_wren(ram_wren), .ram_q(ram_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM stub: byte-enabled write on the edge, registered read two cycles later
   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] q_s0, q_s1;
   always @(posedge clock) begin
      if (ram_wren)
         for (int b = 0; b < BW; b++)
            if (ram_byteena[b]) mem[ram_address[7:0]][8*b +: 8] <= ram_data[8*b +: 8];
      q_s0 <= mem[ram_address[7:0]];
      q_s1 <= q_s0;
   end
   assign ram_q = q_s1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input bit id, input bit req, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [BW-1:0] be);
      if (!id) begin
         r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = data; r0_be = be;
      end else begin
         r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = data; r1_be = be;
      end
   endtask

   task automatic clear_inputs();
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // One granted beat; returns in the cycle after the grant with the request dropped
   task automatic beat(input bit id, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [BW-1:0] be);
      bit got;
      got = 1'b0;
      drive(id, 1'b1, we, addr, data, be);
      for (int i = 0; i < 8; i++) begin
         #1;
         if ((id ? r1_gnt : r0_gnt) === 1'b1) begin
            got = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL beat_grant_timeout r%0d: got no gnt, required gnt within 8 cycles", id);
      end else begin
         step();
      end
      drive(id, 1'b0, we, addr, data, be);
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      r0_req = 1'b1;
      r1_req = 1'b1;
      #2;
      checks++;
      if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, ram_wren} !== 5'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %b required 00000", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, ram_wren});
      end
      checks++;
      if (ram_address !== '0) begin
         failures++;
         $display("FAIL reset_address: got %h required 0", ram_address);
      end
      step();
      clear_inputs();
      rst_n = 1'b1;
      #1;
      checks++;
      if ({r0_gnt, r1_gnt} !== 2'b00) begin
         failures++;
         $display("FAIL reset_release_gnt: got %b required 00", {r0_gnt, r1_gnt});
      end
   endtask

   task automatic test_write_read_r1();
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 19'd1, 32'hCAFEBABE, 4'hF);
      #1;
      checks++;
      if (r1_gnt !== 1'b0) begin
         failures++;
         $display("FAIL wr_idle_gnt: got %b required 0", r1_gnt);
      end
      step();
      checks++;
      if ({r1_gnt, r0_gnt, ram_wren} !== 3'b101 || ram_address !== 19'd1 || ram_data !== 32'hCAFEBABE) begin
         failures++;
         $display("FAIL wr_grant: gnt1/gnt0/wren=%b addr=%h data=%h required 101 1 cafebabe",
                  {r1_gnt, r0_gnt, ram_wren}, ram_address, ram_data);
      end
      step();
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      #1;
      checks++;
      if ({r1_gnt, ram_wren} !== 2'b00) begin
         failures++;
         $display("FAIL wr_drop: gnt/wren=%b required 00", {r1_gnt, ram_wren});
      end
      step();
      drive(1'b1, 1'b1, 1'b0, 19'd1, '0, '0);
      #1;
      checks++;
      if (r1_gnt !== 1'b0) begin
         failures++;
         $display("FAIL rd_idle_gnt: got %b required 0", r1_gnt);
      end
      step();
      checks++;
      if ({r1_gnt, ram_wren} !== 2'b10) begin
         failures++;
         $display("FAIL rd_grant: gnt/wren=%b required 10", {r1_gnt, ram_wren});
      end
      step();
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      #1;
      checks++;
      if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
         failures++;
         $display("FAIL rd_early_rvalid: got %b required 00", {r0_rvalid, r1_rvalid});
      end
      step();
      checks++;
      if ({r0_rvalid, r1_rvalid} !== 2'b01 || r1_rdata !== 32'hCAFEBABE) begin
         failures++;
         $display("FAIL rd_return: rvalid0/1=%b data=%h required 01 cafebabe", {r0_rvalid, r1_rvalid}, r1_rdata);
      end
      step();
      checks++;
      if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
         failures++;
         $display("FAIL rd_single_rvalid: got %b required 00", {r0_rvalid, r1_rvalid});
      end
   endtask

   task automatic test_burst();
      bit exp0;
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 19'h20, '0, '0);
      drive(1'b1, 1'b1, 1'b0, 19'h21, '0, '0);
      #1;
      checks++;
      if ({r0_gnt, r1_gnt} !== 2'b00) begin
         failures++;
         $display("FAIL burst_idle_gnt: got %b required 00", {r0_gnt, r1_gnt});
      end
      for (int i = 0; i < 48; i++) begin
         step();
         exp0 = ((i / 16) % 2) == 0;
         checks++;
         if (r0_gnt !== exp0 || r1_gnt !== !exp0) begin
            failures++;
            $display("FAIL burst_owner beat %0d: gnt0/gnt1=%b%b required %b%b", i, r0_gnt, r1_gnt, exp0, !exp0);
         end
         checks++;
         if (r0_rvalid === 1'b1 && r1_rvalid === 1'b1) begin
            failures++;
            $display("FAIL burst_dual_rvalid beat %0d: got 11 required at most one", i);
         end
      end
      clear_inputs();
      step();
   endtask

   task automatic test_byte_write();
      do_reset();
      beat(1'b0, 1'b1, 19'd5, 32'h11223344, 4'hF);
      beat(1'b0, 1'b1, 19'd5, 32'hAABBCCDD, 4'b0101);
      beat(1'b0, 1'b0, 19'd5, '0, '0);
      step();
      checks++;
      if ({r0_rvalid, r1_rvalid} !== 2'b10 || r0_rdata !== 32'h11BB33DD) begin
         failures++;
         $display("FAIL byte_write: rvalid0/1=%b data=%h required 10 11bb33dd", {r0_rvalid, r1_rvalid}, r0_rdata);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      beat(1'b0, 1'b1, 19'd7, 32'h7, 4'hF);
      beat(1'b1, 1'b1, 19'd8, 32'h8, 4'hF);
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 19'd7, '0, '0);
      drive(1'b1, 1'b1, 1'b0, 19'd8, '0, '0);
      for (int i = 0; i < 16; i++) begin
         step();
         checks++;
         if ({r0_gnt, r1_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_r0_beat %0d: gnt0/gnt1=%b required 10", i, {r0_gnt, r1_gnt});
         end
      end
      step();
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      #1;
      checks++;
      if ({r0_gnt, r1_gnt} !== 2'b01) begin
         failures++;
         $display("FAIL b2b_handover: gnt0/gnt1=%b required 01", {r0_gnt, r1_gnt});
      end
      step();
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      #1;
      checks++;
      if ({r0_rvalid, r1_rvalid} !== 2'b10 || r0_rdata !== 32'h7) begin
         failures++;
         $display("FAIL b2b_r0_return: rvalid0/1=%b data=%h required 10 7", {r0_rvalid, r1_rvalid}, r0_rdata);
      end
      step();
      checks++;
      if ({r0_rvalid, r1_rvalid} !== 2'b01 || r1_rdata !== 32'h8) begin
         failures++;
         $display("FAIL b2b_r1_return: rvalid0/1=%b data=%h required 01 8", {r0_rvalid, r1_rvalid}, r1_rdata);
      end
      step();
      checks++;
      if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
         failures++;
         $display("FAIL b2b_tail: rvalid0/1=%b required 00", {r0_rvalid, r1_rvalid});
      end
   endtask

   task automatic test_reset_inflight();
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 19'd7, '0, '0);
      step();
      step();
      step();
      checks++;
      if ({r0_gnt, r0_rvalid} !== 2'b11) begin
         failures++;
         $display("FAIL inflight_pre: gnt0/rvalid0=%b required 11", {r0_gnt, r0_rvalid});
      end
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      #1;
      checks++;
      if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid} !== 4'b0) begin
         failures++;
         $display("FAIL inflight_reset: gnt/rvalid=%b required 0000", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid});
      end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL inflight_after cycle %0d: rvalid0/1=%b required 00", i, {r0_rvalid, r1_rvalid});
         end
      end
      drive(1'b0, 1'b1, 1'b0, 19'd3, '0, '0);
      drive(1'b1, 1'b1, 1'b0, 19'd4, '0, '0);
      #1;
      checks++;
      if ({r0_gnt, r1_gnt} !== 2'b00) begin
         failures++;
         $display("FAIL inflight_idle: gnt0/gnt1=%b required 00", {r0_gnt, r1_gnt});
      end
      step();
      checks++;
      if ({r0_gnt, r1_gnt} !== 2'b10) begin
         failures++;
         $display("FAIL inflight_r0_first: gnt0/gnt1=%b required 10", {r0_gnt, r1_gnt});
      end
      clear_inputs();
      step();
   endtask

   task automatic test_drop_mid_burst();
      do_reset();
      drive(1'b0, 1'b1, 1'b1, 19'd10, 32'hDEADBEEF, 4'hF);
      step();
      step();
      step();
      checks++;
      if ({r0_gnt, ram_wren} !== 2'b11) begin
         failures++;
         $display("FAIL drop_beat2: gnt0/wren=%b required 11", {r0_gnt, ram_wren});
      end
      step();
      drive(1'b0, 1'b0, 1'b1, 19'd10, 32'hDEADBEEF, 4'hF);
      #1;
      checks++;
      if ({r0_gnt, ram_wren} !== 2'b00) begin
         failures++;
         $display("FAIL drop_beat3: gnt0/wren=%b required 00", {r0_gnt, ram_wren});
      end
      step();
      checks++;
      if ({r0_gnt, r1_gnt, ram_wren} !== 3'b000 || ram_address !== '0) begin
         failures++;
         $display("FAIL drop_idle: gnt/wren=%b addr=%h required 000 0", {r0_gnt, r1_gnt, ram_wren}, ram_address);
      end
      drive(1'b0, 1'b1, 1'b0, 19'd1, '0, '0);
      drive(1'b1, 1'b1, 1'b0, 19'd2, '0, '0);
      step();
      checks++;
      if ({r0_gnt, r1_gnt} !== 2'b01) begin
         failures++;
         $display("FAIL drop_r1_first: gnt0/gnt1=%b required 01", {r0_gnt, r1_gnt});
      end
      clear_inputs();
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_write_read_r1();
      test_burst();
      test_byte_write();
      test_back_to_back();
      test_reset_inflight();
      test_drop_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
